// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Register validity and matching depend on the ISA mode (RISC-V or ARM).
package hazard_pkg;

    typedef enum logic [1:0] {
        S_FILL   = 2'd0,
        S_RUN    = 2'd1,
        S_MDBUSY = 2'd2
    } state_e;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;
    localparam logic [1:0] LOAD_SRC = 2'b01;

    // ARM ignores bit 4 and never treats r15 (PC+8) as a real source.
    function automatic logic reg_valid(input logic arm, input logic [4:0] r);
        return arm ? (r[3:0] != 4'hF) : (r != 5'd0);
    endfunction

    function automatic logic reg_match(input logic arm,
                                       input logic [4:0] a,
                                       input logic [4:0] b);
        return arm ? (a[3:0] == b[3:0]) : (a == b);
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Per-operand forwarding mux select for the Execute stage.
// Memory-stage result takes priority over Writeback.
module fwd_sel
    import hazard_pkg::*;
(
    input  logic       arm,
    input  logic [4:0] RsE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    output logic [1:0] fwd
);

    logic rs_ok;

    always_comb begin
        rs_ok = reg_valid(arm, RsE);
        fwd   = FWD_RF;
        if (rs_ok && RegWriteM && reg_match(arm, RdM, RsE)) begin
            fwd = FWD_MEM;
        end else if (rs_ok && RegWriteW && reg_match(arm, RdW, RsE)) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: post-reset fill, branch flush, load-use
// stall, multi-cycle op stall and Execute-stage operand forwarding.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int FILL_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       arm,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [1:0] ResultSrcE,
    input  logic       PCSrcE,
    input  logic       mdStartE,
    input  logic [3:0] mdCyclesE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       flushD,
    output logic       flushE,
    output logic       flushM,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE
);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       load_use;
    logic       md_go;
    logic [1:0] fwd_a, fwd_b;

    always_comb begin
        load_use = (ResultSrcE == LOAD_SRC) &&
                   ((reg_valid(arm, Rs1D) && reg_match(arm, RdE, Rs1D)) ||
                    (reg_valid(arm, Rs2D) && reg_match(arm, RdE, Rs2D)));
        md_go    = mdStartE && (mdCyclesE >= 4'd2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FILL;
            cnt_q   <= 4'(FILL_CYCLES);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_FILL: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_RUN;
            end
            S_RUN: begin
                if (!PCSrcE && md_go) begin
                    state_d = S_MDBUSY;
                    cnt_d   = mdCyclesE - 4'd1;
                end
            end
            S_MDBUSY: begin
                if (cnt_q > 4'd1) cnt_d = cnt_q - 4'd1;
                else              state_d = S_RUN;
            end
            default: state_d = S_FILL;
        endcase
    end

    // Load-use is Mealy: it reacts to the current Decode/Execute regs.
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        unique case (state_q)
            S_FILL: begin
                stallF = 1'b1;
                flushD = 1'b1;
                flushE = 1'b1;
                flushM = 1'b1;
            end
            S_RUN: begin
                if (PCSrcE) begin
                    flushD = 1'b1;
                    flushE = 1'b1;
                end else if (md_go) begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    stallE = 1'b1;
                    flushM = 1'b1;
                end else if (load_use) begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    flushE = 1'b1;
                end
            end
            S_MDBUSY: begin
                if (cnt_q > 4'd1) begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    stallE = 1'b1;
                    flushM = 1'b1;
                end
            end
            default: begin
                stallF = 1'b1;
                flushD = 1'b1;
                flushE = 1'b1;
                flushM = 1'b1;
            end
        endcase
        ForwardAE = (state_q == S_RUN || state_q == S_MDBUSY) ? fwd_a : FWD_RF;
        ForwardBE = (state_q == S_RUN || state_q == S_MDBUSY) ? fwd_b : FWD_RF;
    end

    fwd_sel u_fwd_a (
        .arm      (arm),
        .RsE      (Rs1E),
        .RdM      (RdM),
        .RdW      (RdW),
        .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW),
        .fwd      (fwd_a)
    );

    fwd_sel u_fwd_b (
        .arm      (arm),
        .RsE      (Rs2E),
        .RdM      (RdM),
        .RdW      (RdW),
        .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW),
        .fwd      (fwd_b)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: driver queues expected outputs,
// monitor compares them on the falling edge.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       arm;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0] ResultSrcE;
    logic       PCSrcE, mdStartE, RegWriteM, RegWriteW;
    logic [3:0] mdCyclesE;
    logic       stallF, stallD, stallE, flushD, flushE, flushM;
    logic [1:0] ForwardAE, ForwardBE;

    int checks = 0;
    int errors = 0;

    string      nm_q[$];
    logic [9:0] ex_q[$];

    always #5 clk = ~clk;

    hazard_ctrl #(.FILL_CYCLES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .arm       (arm),
        .Rs1D      (Rs1D),
        .Rs2D      (Rs2D),
        .Rs1E      (Rs1E),
        .Rs2E      (Rs2E),
        .RdE       (RdE),
        .ResultSrcE(ResultSrcE),
        .PCSrcE    (PCSrcE),
        .mdStartE  (mdStartE),
        .mdCyclesE (mdCyclesE),
        .RdM       (RdM),
        .RdW       (RdW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .stallF    (stallF),
        .stallD    (stallD),
        .stallE    (stallE),
        .flushD    (flushD),
        .flushE    (flushE),
        .flushM    (flushM),
        .ForwardAE (ForwardAE),
        .ForwardBE (ForwardBE)
    );

    // {stallF,stallD,stallE,flushD,flushE,flushM,ForwardAE,ForwardBE}
    function automatic logic [9:0] ex(input logic sf, input logic sd,
                                      input logic se, input logic fd,
                                      input logic fe, input logic fm,
                                      input logic [1:0] fa,
                                      input logic [1:0] fb);
        return {sf, sd, se, fd, fe, fm, fa, fb};
    endfunction

    localparam logic [9:0] E_FILL  = 10'b1001110000;
    localparam logic [9:0] E_IDLE  = 10'b0000000000;
    localparam logic [9:0] E_STALL = 10'b1110010000;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input logic [9:0] e);
        nm_q.push_back(nm);
        ex_q.push_back(e);
    endtask

    task automatic clear_in();
        arm = 0; Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0;
        RdM = 0; RdW = 0; ResultSrcE = 0; PCSrcE = 0; mdStartE = 0;
        mdCyclesE = 0; RegWriteM = 0; RegWriteW = 0;
    endtask

    always @(negedge clk) begin
        if (ex_q.size() > 0) begin
            string      nm;
            logic [9:0] e, got;
            nm  = nm_q.pop_front();
            e   = ex_q.pop_front();
            got = {stallF, stallD, stallE, flushD, flushE, flushM,
                   ForwardAE, ForwardBE};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s got=%b exp=%b", nm, got, e);
            end
        end
    end

    initial begin
        clear_in();
        rst = 1'b1;
        tick(); expect_out("rst_hold0", E_FILL);
        tick(); expect_out("rst_hold1", E_FILL);
        tick(); rst = 1'b0; expect_out("fill1", E_FILL);
        tick(); expect_out("fill2", E_FILL);
        tick(); expect_out("run_idle", E_IDLE);

        // forwarding
        tick(); RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5;
        expect_out("fwd_mem_wins", ex(0,0,0,0,0,0,2'b10,2'b00));
        tick(); RegWriteM = 0;
        expect_out("fwd_wb", ex(0,0,0,0,0,0,2'b01,2'b00));
        tick(); RegWriteM = 1; Rs1E = 0; RdM = 0; RdW = 0;
        expect_out("fwd_x0", E_IDLE);
        tick(); clear_in(); arm = 1; Rs2E = 15; RdM = 15; RegWriteM = 1;
        expect_out("fwd_arm_r15", E_IDLE);
        tick(); Rs2E = 5'h13; RdM = 5'h03;
        expect_out("fwd_arm_bit4", ex(0,0,0,0,0,0,2'b00,2'b10));
        tick(); clear_in(); expect_out("idle2", E_IDLE);

        // load-use and branch priority
        tick(); ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
        expect_out("load_use", ex(1,1,0,0,1,0,2'b00,2'b00));
        tick(); PCSrcE = 1;
        expect_out("branch_over_lu", ex(0,0,0,1,1,0,2'b00,2'b00));
        tick(); clear_in(); ResultSrcE = 2'b01;
        expect_out("load_x0", E_IDLE);
        tick(); clear_in(); expect_out("idle3", E_IDLE);

        // multi-cycle op N=4, ignoring events while busy
        tick(); mdStartE = 1; mdCyclesE = 4;
        expect_out("md4_s1", E_STALL);
        tick(); mdStartE = 0; Rs1E = 5; RdM = 5; RegWriteM = 1;
        expect_out("md4_s2_fwd", ex(1,1,1,0,0,1,2'b10,2'b00));
        tick(); clear_in(); PCSrcE = 1; ResultSrcE = 2'b01;
        RdE = 3; Rs1D = 3; mdStartE = 1; mdCyclesE = 4;
        expect_out("md4_s3_ignore", E_STALL);
        tick(); expect_out("md4_done", E_IDLE);
        tick(); clear_in(); expect_out("md4_after", E_IDLE);

        tick(); mdStartE = 1; mdCyclesE = 1;
        expect_out("md1_nostall", E_IDLE);
        tick(); mdCyclesE = 0; expect_out("md0_nostall", E_IDLE);
        tick(); mdCyclesE = 2; expect_out("md2_s1", E_STALL);
        tick(); clear_in(); expect_out("md2_done", E_IDLE);
        tick(); expect_out("md2_after", E_IDLE);

        // reset during MDBUSY
        tick(); mdStartE = 1; mdCyclesE = 4;
        expect_out("mdr_s1", E_STALL);
        tick(); mdStartE = 0; expect_out("mdr_s2", E_STALL);
        tick(); rst = 1; expect_out("mdr_rst", E_FILL);
        tick(); rst = 0; Rs1E = 5; RdM = 5; RegWriteM = 1;
        expect_out("mdr_fill1_fwd0", E_FILL);
        tick(); expect_out("mdr_fill2", E_FILL);
        tick(); expect_out("mdr_run_fwd", ex(0,0,0,0,0,0,2'b10,2'b00));
        tick(); clear_in(); expect_out("mdr_idle", E_IDLE);

        for (int i = 0; i < 10 && ex_q.size() > 0; i++) tick();
        if (ex_q.size() > 0) begin
            errors++;
            $display("FAIL drain got=%0d exp=0 pending", ex_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter FILL_CYCLES, default 2, post-reset pipeline fill cycles (≥1).
REQ-002 SHALL have ports, one clock; reset is asynchronous and active-high:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- arm  in  1  1 = ARM mode, 0 = RISC-V mode
- Rs1D, Rs2D  in  5 each  source regs in Decode
- Rs1E, Rs2E, RdE  in  5 each  source/dest regs in Execute
- ResultSrcE  in  2  01 = load in Execute
- PCSrcE  in  1  taken branch/jump redirect from Execute
- mdStartE  in  1  multi-cycle op present in Execute
- mdCyclesE  in  4  latency N of that op
- RdM, RdW  in  5 each  dest regs in Memory/Writeback
- RegWriteM, RegWriteW  in  1 each  write enables
- stallF, stallD, stallE  out  1 each  hold stage registers
- flushD, flushE, flushM  out  1 each  bubble stage registers
- ForwardAE, ForwardBE  out  2 each  00 = regfile, 01 = Writeback, 10 = Memory

Function
REQ-003 SHALL implement FSM states FILL, RUN, MDBUSY, plus a 4-bit fill/latency counter cnt.
REQ-004 FILL: stallF=1, flushD=1, flushE=1, flushM=1, other stall/flush outputs 0; cnt decrements each cycle; go to RUN when cnt==1.
REQ-005 RUN, priority 1: PCSrcE=1 -> flushD=1, flushE=1, no stalls; load-use and mdStartE ignored that cycle.
REQ-006 RUN, priority 2: mdStartE=1 with mdCyclesE≥2 -> stallF=stallD=stallE=1, flushM=1; load cnt=mdCyclesE-1; go to MDBUSY.
REQ-007 RUN, priority 2, mdCyclesE∈{0,1}: SHALL NOT stall.
REQ-008 RUN, priority 3: load-use (ResultSrcE==01, RdE matches a valid Rs1D or Rs2D) -> stallF=1, stallD=1, flushE=1 that cycle (Mealy).
REQ-009 MDBUSY, cnt>1: stallF=stallD=stallE=1, flushM=1, cnt decrements.
REQ-010 MDBUSY, cnt==1: no stall or flush outputs; go to RUN.
REQ-011 MDBUSY: mdStartE, PCSrcE and load-use SHALL be ignored.
REQ-012 Total stall cycles for an op with N≥2 SHALL equal N-1.
REQ-013 Register validity: RISC-V, index 0 is never valid; ARM, index 15 is never valid (r15 is PC+8) and bit 4 is ignored.
REQ-014 ForwardAE: 10 if RegWriteM && RdM==Rs1E && Rs1E valid; else 01 if RegWriteW && RdW==Rs1E && Rs1E valid; else 00. Memory SHALL win when both match. ForwardBE is the same rule using Rs2E.
REQ-015 Forwarding SHALL be combinational, active in every state except FILL, where it is 00.
REQ-016 Stall and flush of the same stage SHALL never both be 1.

Reset
REQ-017 rst=1 SHALL asynchronously force state=FILL and cnt=FILL_CYCLES.
REQ-018 While rst=1 and during FILL, outputs SHALL take their FILL values (REQ-004, forwarding 00).
REQ-019 rst asserted mid-MDBUSY SHALL abandon the count; no stall carries over after FILL.

Structure
REQ-020 A shared package hazard_pkg SHALL hold the FSM state enum, FWD_RF/FWD_WB/FWD_MEM constants, and LOAD_SRC=2'b01.
REQ-021 SHALL contain one sub-module fwd_sel, combinational, instantiated twice (A, B), inputs arm/RsE/RdM/RdW/RegWriteM/RegWriteW.

Verification
REQ-022 Reset release, FILL_CYCLES=2 -> stallF, flushD, flushE, flushM high exactly 2 cycles, then all 0.
REQ-023 RISC-V: RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10. Same with Rs1E=0 -> 00. ARM, Rs2E=15, RdM=15 -> ForwardBE=00.
REQ-024 ResultSrcE=01, RdE=7, Rs2D=7 -> one cycle stallF=stallD=flushE=1. Same cycle PCSrcE=1 -> flushD=flushE=1, stalls 0.
REQ-025 mdStartE=1, mdCyclesE=4 -> stallF/D/E=1, flushM=1 for exactly 3 cycles; mdCyclesE=1 -> no stall.
REQ-026 rst pulse in 2nd MDBUSY cycle -> immediate FILL outputs; after FILL, RUN with no residual stall.
